hazard_ctrl: RTL

Hazard and stall controller for the five-stage MIPS pipeline. It tracks, per stage, the destination register and remaining result latency (Tnew) of every instruction in E, M and W. From that state it produces the D-stage stall, the E-stage bubble, the mux selects for the D- and E-stage forwarding network, and the busy interlock for the multi-cycle mult/div unit. It sits beside the decode stage and is the sole source of pipeline-freeze decisions.

---
 rtl/hazard_ctrl.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall, bubble, forwarding-select and mult/div interlock logic
// for a five-stage MIPS pipeline. It tracks the destination register and
// remaining result latency (Tnew) of the instructions in E, M and W and
// compares them against the operand deadlines (Tuse) of the instruction in D.
// All outputs are combinational from registered state plus the current D inputs.
module hazard_ctrl #(
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       D_valid,
  input  logic [4:0] D_RSA,
  input  logic [4:0] D_RTA,
  input  logic [1:0] D_tuse_rs,
  input  logic [1:0] D_tuse_rt,
  input  logic [4:0] D_WA,
  input  logic [1:0] D_tnew,
  input  logic       D_md_start,
  input  logic       D_md_div,
  input  logic       D_md_use,
  output logic       stall,
  output logic       E_clr,
  output logic       md_busy,
  output logic [1:0] fsel_rs_d,
  output logic [1:0] fsel_rt_d,
  output logic [1:0] fsel_rs_e,
  output logic [1:0] fsel_rt_e
);

  // Busy-counter reload values; the counter is 4 bits wide, so DIV_CYC <= 15.
  localparam logic [3:0] MULT_LD = 4'(MULT_CYC);
  localparam logic [3:0] DIV_LD  = 4'(DIV_CYC);

  // Forwarding-select encodings.
  localparam logic [1:0] SEL_NONE = 2'd0;
  localparam logic [1:0] SEL_NEAR = 2'd1;  // E result (D side) / M result (E side)
  localparam logic [1:0] SEL_FAR  = 2'd2;  // M result (D side) / W result (E side)

  // Everything the E stage remembers about its instruction.
  typedef struct packed {
    logic [4:0] wa;
    logic [1:0] tnew;
    logic [4:0] rsa;
    logic [4:0] rta;
    logic       md_start;
    logic       md_div;
  } e_stage_t;

  e_stage_t   e_q;
  e_stage_t   e_d;
  logic [4:0] m_wa;
  logic [1:0] m_tnew;
  logic [4:0] w_wa;
  logic [3:0] md_cnt;

  logic       rs_stall;
  logic       rt_stall;
  logic       data_stall;
  logic       md_stall;

  // Register $0 is hard-wired to zero, so it never produces a dependency.
  function automatic logic hit(input logic [4:0] src, input logic [4:0] dst);
    return (src == dst) && (src != 5'd0);
  endfunction

  // A source stalls when a producer in E or M cannot deliver before its Tuse.
  function automatic logic src_stall(
    input logic       valid,
    input logic [4:0] src,
    input logic [1:0] tuse,
    input logic [4:0] ewa,
    input logic [1:0] etnew,
    input logic [4:0] mwa,
    input logic [1:0] mtnew
  );
    if (!valid || (tuse == 2'd3)) begin
      return 1'b0;
    end
    return (hit(src, ewa) && (etnew > tuse)) || (hit(src, mwa) && (mtnew > tuse));
  endfunction

  // D-side select: the younger producer in E wins over M.
  function automatic logic [1:0] sel_d(
    input logic [4:0] src,
    input logic [4:0] ewa,
    input logic [1:0] etnew,
    input logic [4:0] mwa,
    input logic [1:0] mtnew
  );
    if (hit(src, ewa) && (etnew == 2'd0)) begin
      return SEL_NEAR;
    end
    if (hit(src, mwa) && (mtnew == 2'd0)) begin
      return SEL_FAR;
    end
    return SEL_NONE;
  endfunction

  // E-side select: M result when ready, else the W result.
  function automatic logic [1:0] sel_e(
    input logic [4:0] src,
    input logic [4:0] mwa,
    input logic [1:0] mtnew,
    input logic [4:0] wwa
  );
    if (hit(src, mwa) && (mtnew == 2'd0)) begin
      return SEL_NEAR;
    end
    if (hit(src, wwa)) begin
      return SEL_FAR;
    end
    return SEL_NONE;
  endfunction

  // Freeze decision and forwarding selects from current state and D inputs.
  always_comb begin
    rs_stall   = src_stall(D_valid, D_RSA, D_tuse_rs, e_q.wa, e_q.tnew, m_wa, m_tnew);
    rt_stall   = src_stall(D_valid, D_RTA, D_tuse_rt, e_q.wa, e_q.tnew, m_wa, m_tnew);
    data_stall = rs_stall | rt_stall;
    md_busy    = e_q.md_start | (md_cnt != 4'd0);
    md_stall   = D_valid & D_md_use & md_busy;
    stall      = data_stall | md_stall;
    E_clr      = stall;
    fsel_rs_d  = sel_d(D_RSA, e_q.wa, e_q.tnew, m_wa, m_tnew);
    fsel_rt_d  = sel_d(D_RTA, e_q.wa, e_q.tnew, m_wa, m_tnew);
    fsel_rs_e  = sel_e(e_q.rsa, m_wa, m_tnew, w_wa);
    fsel_rt_e  = sel_e(e_q.rta, m_wa, m_tnew, w_wa);
  end

  // Next E contents: the D instruction, or a bubble when stalled or empty.
  always_comb begin
    // NOTE: default first so every path assigns e_d and no latch is inferred.
    e_d = '0;
    if (D_valid && !stall) begin
      e_d.wa       = D_WA;
      e_d.tnew     = D_tnew;
      e_d.rsa      = D_RSA;
      e_d.rta      = D_RTA;
      e_d.md_start = D_md_start;
      e_d.md_div   = D_md_div;
    end
  end

  // Pipeline shadow: M and W always advance; E takes D or a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q    <= '0;
      m_wa   <= '0;
      m_tnew <= '0;
      w_wa   <= '0;
    end else begin
      // NOTE: non-blocking so every stage samples the pre-edge value of the one before.
      w_wa   <= m_wa;
      m_wa   <= e_q.wa;
      m_tnew <= (e_q.tnew == 2'd0) ? 2'd0 : e_q.tnew - 2'd1;
      e_q    <= e_d;
    end
  end

  // Mult/div busy counter: reload when an op sits in E, then count down to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_cnt <= '0;
    end else if (e_q.md_start) begin
      md_cnt <= e_q.md_div ? DIV_LD : MULT_LD;
    end else if (md_cnt != 4'd0) begin
      md_cnt <= md_cnt - 4'd1;
    end
  end

endmodule
